// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and default base.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [63:0] DmemAddrBase = 64'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store data/mask placement and load extraction with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  bmask_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  shamt;
  logic [63:0] rsh;

  always_comb begin
    shamt   = {lane_i, 3'b000};
    wdata_o = wdata_i << shamt;
    rsh     = rword_i >> shamt;
    bmask_o = 8'hff;
    rdata_o = rsh;
    case (size_i)
      SZ_B: begin
        bmask_o = 8'h01 << lane_i;
        rdata_o = unsigned_i ? {56'd0, rsh[7:0]} : {{56{rsh[7]}}, rsh[7:0]};
      end
      SZ_H: begin
        bmask_o = 8'h03 << lane_i;
        rdata_o = unsigned_i ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      end
      SZ_W: begin
        bmask_o = 8'h0f << lane_i;
        rdata_o = unsigned_i ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      end
      default: begin
        bmask_o = 8'hff;
        rdata_o = rsh;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Stallable data-memory responder: one request at a time, fixed latency, registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE   = DmemAddrBase,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e       state_q;
  logic [CntW-1:0]   cnt_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [63:0]       addr_q;
  logic [63:0]       wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [63:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [63:0]       mem_q [DEPTH_WORDS];

  logic [63:0]       offset;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic [IdxW-1:0]   word_idx;
  logic [63:0]       rword;
  logic              commit;
  logic [63:0]       wdata_sh;
  logic [7:0]        bmask;
  logic [63:0]       rdata_ext;

  always_comb begin
    offset       = addr_q - ADDR_BASE;
    misaligned   = (addr_q & ((64'd1 << size_q) - 64'd1)) != 64'd0;
    // Compare the full word offset so addresses past the end never alias low words.
    out_of_range = (addr_q < ADDR_BASE) || ((offset >> 3) >= 64'(DEPTH_WORDS));
    acc_err      = misaligned | out_of_range;
    word_idx     = offset[IdxW+2:3];
    rword        = mem_q[word_idx];
    commit       = (state_q == StWait) && (cnt_q == '0);
  end

  dmem_lane_align u_lane_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .lane_i     (addr_q[2:0]),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .wdata_o    (wdata_sh),
    .bmask_o    (bmask),
    .rdata_o    (rdata_ext)
  );

  // Array is not reset; a reset at the commit edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && write_q && !acc_err) begin
      for (int b = 0; b < 8; b++) begin
        if (bmask[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            write_q     <= req_write_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            cnt_q       <= CntW'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= (acc_err || write_q) ? 64'd0 : rdata_ext;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table through a response scoreboard plus
// hand-written stall and mid-operation reset sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 4096;
  localparam logic [63:0] Base  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_BASE   (Base),
    .DEPTH_WORDS (Depth),
    .LATENCY     (Lat)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err)
  );

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check(name, 64'(req_ready), 64'd1);
  endtask

  // Issue one request, check latency, compare against scoreboard, optionally stall the response.
  task automatic do_req(input vec_t v, input int hold, input string name);
    exp_t e;
    int   n;
    int   lat;
    logic acc;
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    req_valid = 1'b1; req_write = v.w; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      acc = req_ready;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    e = exp_q.pop_front();
    if (!acc) begin
      check({name, " accept timeout"}, 64'd0, 64'd1);
      return;
    end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(Lat));
    check({name, " rdata"}, resp_rdata, e.rdata);
    check({name, " err"}, 64'(resp_err), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold valid"}, 64'(resp_valid), 64'd1);
      check({name, " hold rdata"}, resp_rdata, e.rdata);
      check({name, " hold err"}, 64'(resp_err), 64'(e.err));
      check({name, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, " valid drop"}, 64'(resp_valid), 64'd0);
    check({name, " ready back"}, 64'(req_ready), 64'd1);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    vecs.push_back('{1'b1, SZ_D, 1'b0, 64'h8000_0000, 64'hA5A5_A5A5_5A5A_5A5A, 64'd0, 1'b0});
    vecs.push_back('{1'b1, SZ_D, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 1'b0});
    vecs.push_back('{1'b0, SZ_D, 1'b0, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 1'b1, 64'h8000_000C, 64'd0, 64'h0000_0000_1122_3344, 1'b0});
    vecs.push_back('{1'b1, SZ_D, 1'b0, 64'h8000_0010, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{1'b1, SZ_B, 1'b0, 64'h8000_0013, 64'h0000_0000_0000_0080, 64'd0, 1'b0});
    vecs.push_back('{1'b0, SZ_B, 1'b0, 64'h8000_0013, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0});
    vecs.push_back('{1'b0, SZ_B, 1'b1, 64'h8000_0013, 64'd0, 64'h0000_0000_0000_0080, 1'b0});
    vecs.push_back('{1'b0, SZ_D, 1'b0, 64'h8000_0010, 64'd0, 64'h0000_0000_8000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_H, 1'b0, 64'h8000_0012, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 1'b0, 64'h8000_0010, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{1'b1, SZ_D, 1'b0, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1'b1});
    vecs.push_back('{1'b1, SZ_W, 1'b0, 64'h8000_0006, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1'b1});
    vecs.push_back('{1'b0, SZ_D, 1'b0, 64'h8000_0000, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0});
    vecs.push_back('{1'b0, SZ_D, 1'b0, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0});
    vecs.push_back('{1'b1, SZ_D, 1'b0, Base + 64'(8 * (Depth - 1)), 64'hCAFE_F00D_1234_5678,
                     64'd0, 1'b0});
    vecs.push_back('{1'b0, SZ_D, 1'b0, Base + 64'(8 * (Depth - 1)), 64'd0,
                     64'hCAFE_F00D_1234_5678, 1'b0});
    vecs.push_back('{1'b1, SZ_D, 1'b0, Base + 64'(8 * Depth), 64'h0BAD_0BAD_0BAD_0BAD,
                     64'd0, 1'b1});
    vecs.push_back('{1'b0, SZ_D, 1'b0, 64'h8000_0000, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0});

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_rdata", resp_rdata, 64'd0);
    check("reset resp_err", 64'(resp_err), 64'd0);
    rst = 1'b0;
    wait_ready("post-reset ready");

    foreach (vecs[i]) do_req(vecs[i], 0, $sformatf("vec%0d", i));

    // Stalled response: outputs hold while resp_ready stays low.
    v = '{1'b0, SZ_D, 1'b0, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0};
    do_req(v, 5, "stall");

    // Reset in the first WAIT cycle drops the store.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_D; req_unsigned = 1'b0;
    req_addr = 64'h8000_0008; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst accepted", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst req_ready", 64'(req_ready), 64'd0);
    check("midrst resp_valid", 64'(resp_valid), 64'd0);
    check("midrst resp_rdata", resp_rdata, 64'd0);
    check("midrst resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst no early valid", 64'(resp_valid), 64'd0);
    wait_ready("midrst ready");
    v = '{1'b0, SZ_D, 1'b0, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0};
    do_req(v, 0, "midrst reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle RV64 core. It is the far end of the core's store/load interface and serves both directions.
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs the access on an internal 64-bit-wide memory array after a fixed latency.
- Returns a response (load data or store acknowledge, plus error flag) over a second valid/ready handshake.
- Gives the core a realistic, stallable memory model in place of a combinational store sink.

Parameters:
- ADDR_BASE, 64'h8000_0000: byte address that maps to array word 0.
- DEPTH_WORDS, 4096: number of 64-bit words in the array. Must be a power of two.
- LATENCY, 2: cycles from request acceptance to first resp_valid. Must be >= 1.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0. Ignored for stores.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned (valid bits are [8<<size - 1 : 0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  64  load result, extended to 64 bits. 0 for stores and for errors.
- resp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready = 0 during the reset cycle, 1 in IDLE afterwards.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Latency counter = 0.
  - Array contents are not reset.
- States:
  - IDLE: req_ready = 1.
    - On req_valid & req_ready, capture write, size, unsigned, addr and wdata into holding registers.
    - Load counter = LATENCY - 1 and go to WAIT.
  - WAIT: req_ready = 0. Counter decrements each cycle.
    - When counter == 0, commit the access at that edge:
      - Store: write the array.
      - Load: register the extracted data.
    - Then go to RESP.
  - RESP: resp_valid = 1, req_ready = 0.
    - resp_rdata and resp_err stay stable until resp_ready.
    - On resp_valid & resp_ready, go to IDLE. resp_valid drops the next cycle.
- Latency: a request accepted at edge T gives resp_valid high in the cycle after edge T + LATENCY. There is no overlap; the next request is accepted no earlier than the cycle after the response handshake.
- Error checks, evaluated on the captured request:
  - Misaligned: (addr & ((1<<size) - 1)) != 0.
  - Out of range: addr < ADDR_BASE, or ((addr - ADDR_BASE) >> 3) >= DEPTH_WORDS.
  - On error: resp_err = 1, resp_rdata = 0, and the array is not modified.
- Store:
  - Word index = (addr - ADDR_BASE) >> 3. Byte lane = addr[2:0].
  - Write data = wdata << (8 * lane).
  - Byte mask = ((1 << (1<<size)) - 1) << lane.
  - Only masked bytes change. resp_rdata = 0.
- Load:
  - Read the word and shift right by 8 * lane.
  - Truncate to the access size, then sign- or zero-extend per req_unsigned.
  - Dword loads ignore req_unsigned.
- A write committed at edge E is visible to any load accepted after E (no read-after-write hazard, since there is only one outstanding request).
- Reset mid-operation: a pending request in WAIT is dropped. No array write occurs if reset is asserted at or before the commit edge. A request in RESP is discarded.
- req_valid while not in IDLE is ignored. The core must hold its request until req_ready.

Decomposition:
- Package dmem_pkg contains:
  - The size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D).
  - The state enum (IDLE, WAIT, RESP).
  - The default ADDR_BASE.
- One combinational sub-module, dmem_lane_align, handles:
  - Store shift and byte-mask generation.
  - Load shift, truncation and extension.
- The array, the counter and the FSM stay in dmem_responder.

Test Plan (LATENCY = 2):
1. Store dword 0x1122334455667788 at 0x8000_0008, then load dword from the same address.
   - Required: rdata = 0x1122334455667788, err = 0.
   - resp_valid rises exactly 2 cycles after each acceptance.
2. Byte store of 0x80 at 0x8000_0013 over a word preloaded to 0.
   - Signed byte load returns 0xFFFF_FFFF_FFFF_FF80.
   - Unsigned byte load returns 0x80.
   - Dword load at 0x8000_0010 returns 0x0000_0000_8000_0000.
3. Word load at 0x8000_0002 (misaligned) and dword store at 0x7FFF_FFF8 (below base).
   - Required: err = 1, rdata = 0, and a subsequent load shows the array unchanged.
4. Hold resp_ready = 0 for 5 cycles after a load response appears.
   - Required: resp_valid, rdata and err stay stable and req_ready stays 0.
   - Required: on resp_ready = 1, a one-cycle handshake, then req_ready = 1.
5. Store accepted, then rst asserted in the first WAIT cycle.
   - Required: outputs return to their reset values.
   - Required: a later load at the same address returns the prior contents (no write).
6. Dword store at ADDR_BASE + 8*(DEPTH_WORDS - 1), then at ADDR_BASE + 8*DEPTH_WORDS.
   - Required: the first succeeds with err = 0.
   - Required: the second returns err = 1, with no wrap-around write to word 0.
